// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide sequencer for the EX stage. It owns the HI/LO register pair.
//   - MULT/MULTU: one registered multiply step, then FIN.
//   - DIV/DIVU  : 32-step restoring divider on operand magnitudes, with a sign
//                 fixup on the final step.
//   - MTHI/MTLO : direct writes of src_a in IDLE or FIN, with no stall.
//   - MFHI/MFLO : hilo_rdata is a combinational view of the registers.
//   - flush     : abandons any in-flight operation and suppresses its result.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   start_valid         EX instruction valid and (mult or div)
//   mult, div, mdsign   operation select and signedness from the decoder
//   src_a, src_b        operands; src_a also carries MTHI/MTLO write data
//   hilowen[1:0]        bit0 writes LO, bit1 writes HI
//   hiloren[1:0]        2'b01 reads LO, 2'b10 reads HI
//   flush               exception/ERET cancel
//   stall, busy         pipeline hold and "sequencer not idle"
//   hilo_rdata, hi, lo  read port and raw register values
//
// Optional build macro: MDU_DIV0_EARLY_EN
//   When defined, a zero divisor is detected in the first DIV cycle. The
//   divide-by-zero result is written on that cycle, so the divide finishes
//   early. HI/LO values are the same as in the default build.
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  input  logic        mult,
  input  logic        div,
  input  logic        mdsign,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  hilowen,
  input  logic [1:0]  hiloren,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  localparam logic [5:0] LAST_STEP = 6'(DIV_ITER - 1);

  state_t      state_reg;
  logic [31:0] a_reg;          // operand magnitude (dividend / multiplicand)
  logic [31:0] b_reg;          // operand magnitude (divisor / multiplier)
  logic        sign_a_reg;     // only set for signed operations
  logic        sign_b_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [5:0]  cnt_reg;

  // Index 0 is LO and index 1 is HI, so hilowen[gi] selects the same entry.
  logic [31:0] hilo_reg  [2];
  logic [31:0] hilo_next [2];
  logic [31:0] res_word  [2];
  logic        res_we;

  // Decoder guarantees start_valid implies mult or div; anything not a
  // multiply is treated as a divide.
  logic unused_div;
  assign unused_div = div;

  // ---------------------------------------------------------------------------
  // Operand magnitudes at accept time
  // ---------------------------------------------------------------------------
  logic [31:0] abs_a, abs_b;
  assign abs_a = (mdsign && src_a[31]) ? -src_a : src_a;
  assign abs_b = (mdsign && src_b[31]) ? -src_b : src_b;

  // ---------------------------------------------------------------------------
  // Multiply datapath
  // ---------------------------------------------------------------------------
  logic [63:0] prod_mag, prod;
  assign prod_mag = {32'd0, a_reg} * {32'd0, b_reg};
  assign prod     = (sign_a_reg ^ sign_b_reg) ? -prod_mag : prod_mag;

  // ---------------------------------------------------------------------------
  // Restoring divide step
  // ---------------------------------------------------------------------------
  // The remainder stays below the divisor, so the shifted remainder needs at
  // most 33 bits. Bit 32 of the difference acts as the borrow. Without a
  // borrow, the subtraction fits back into 32 bits.
  logic [32:0] rem_sh, rem_diff;
  logic        div_ge;
  logic [31:0] rem_step, quo_step;
  assign rem_sh   = {rem_reg, quo_reg[31]};
  assign rem_diff = rem_sh - {1'b0, b_reg};
  assign div_ge   = ~rem_diff[32];
  assign rem_step = div_ge ? rem_diff[31:0] : rem_sh[31:0];
  assign quo_step = {quo_reg[30:0], div_ge};

  logic div0_early;
`ifdef MDU_DIV0_EARLY_EN
  assign div0_early = (cnt_reg == 6'd0) && (b_reg == 32'd0);
`else
  assign div0_early = 1'b0;
`endif

  // The early result is the value that 32 steps against a zero divisor would
  // produce: all ones for the quotient and the dividend for the remainder.
  logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix;
  logic        div_done;
  assign quo_raw  = div0_early ? 32'hFFFF_FFFF : quo_step;
  assign rem_raw  = div0_early ? a_reg : rem_step;
  assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? -quo_raw : quo_raw;
  assign rem_fix  = sign_a_reg ? -rem_raw : rem_raw;
  assign div_done = (cnt_reg == LAST_STEP) || div0_early;

  // ---------------------------------------------------------------------------
  // HI/LO write selection
  // ---------------------------------------------------------------------------
  always_comb begin
    res_we      = 1'b0;
    res_word[0] = prod[31:0];
    res_word[1] = prod[63:32];
    if (state_reg == MUL) begin
      res_we = 1'b1;
    end else if (state_reg == DIV && div_done) begin
      res_we      = 1'b1;
      res_word[0] = quo_fix;
      res_word[1] = rem_fix;
    end
  end

  logic mt_ok;
  assign mt_ok = (state_reg == IDLE) || (state_reg == FIN);

  // A flush blocks every write. On the same edge, an operation result takes
  // priority over MTHI/MTLO.
  for (genvar gi = 0; gi < 2; gi++) begin : g_hilo
    assign hilo_next[gi] = flush                   ? hilo_reg[gi] :
                           res_we                  ? res_word[gi] :
                           (mt_ok && hilowen[gi])  ? src_a        :
                                                     hilo_reg[gi];
  end

  // ---------------------------------------------------------------------------
  // Sequencer and state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      hilo_reg[0] <= '0;
      hilo_reg[1] <= '0;
    end else begin
      hilo_reg[0] <= hilo_next[0];
      hilo_reg[1] <= hilo_next[1];
      if (flush) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_valid) begin
              a_reg      <= abs_a;
              b_reg      <= abs_b;
              sign_a_reg <= mdsign & src_a[31];
              sign_b_reg <= mdsign & src_b[31];
              rem_reg    <= '0;
              quo_reg    <= abs_a;
              cnt_reg    <= '0;
              state_reg  <= mult ? MUL : DIV;
            end
          end
          MUL: state_reg <= FIN;
          DIV: begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + 6'd1;
            if (div_done) state_reg <= FIN;
          end
          // The held instruction is still presented here, so start_valid is
          // ignored to avoid issuing the same operation twice.
          FIN:     state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stall = !flush && (((state_reg == IDLE) && start_valid) ||
                            (state_reg == MUL) || (state_reg == DIV));
  assign busy  = (state_reg != IDLE);
  assign lo    = hilo_reg[0];
  assign hi    = hilo_reg[1];

  always_comb begin
    case (hiloren)
      2'b01:   hilo_rdata = hilo_reg[0];
      2'b10:   hilo_rdata = hilo_reg[1];
      default: hilo_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
// Self-checking bench for mdu_ctrl. A plain-arithmetic reference model gives
// the expected HI/LO values. Stall lengths come from the documented latencies.
// Build macro MDU_DIV0_EARLY_EN selects the expected divide-by-zero latency.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid, mult, div, mdsign, flush;
  logic [31:0] src_a, src_b;
  logic [1:0]  hilowen, hiloren;
  logic        stall, busy;
  logic [31:0] hilo_rdata, hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef MDU_DIV0_EARLY_EN
  localparam int DIV0_STALL = 2;
`else
  localparam int DIV0_STALL = 33;
`endif

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .mult       (mult),
    .div        (div),
    .mdsign     (mdsign),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilowen    (hilowen),
    .hiloren    (hiloren),
    .flush      (flush),
    .stall      (stall),
    .busy       (busy),
    .hilo_rdata (hilo_rdata),
    .hi         (hi),
    .lo         (lo)
  );

  // Reference model. It returns {hi, lo}.
  function automatic logic [63:0] model(input bit is_mult, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, t;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'd0, a} * {32'd0, b};
      return p;
    end
    if (b == 32'd0) begin
      // Unsigned: all-ones quotient and the dividend as remainder. In the
      // signed case the divisor sign is 0, so a negative dividend negates the
      // all-ones quotient to 1. The remainder |a| gets the dividend's sign
      // back, which gives a.
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      t = sa / sb; q = t[31:0];
      t = sa % sb; r = t[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      2:       return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one operation and keeps it presented while stall is high, as the
  // pipeline would. It returns the stall cycle count and busy in the first
  // unstalled cycle (FIN). It ends after FIN, with the sequencer back in IDLE.
  task automatic run_op(input bit is_mult, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output logic fin_busy);
    @(negedge clk);
    start_valid = 1'b1; mult = is_mult; div = !is_mult; mdsign = sgn;
    src_a = a; src_b = b;
    n_stall = 0;
    #1;
    while (stall === 1'b1 && n_stall <= 100) begin
      n_stall++;
      @(negedge clk);
      #1;
    end
    fin_busy = busy;
    @(negedge clk);
    start_valid = 1'b0; mult = 1'b0; div = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    hiloren = 2'b10;
    #1;
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (hilo_rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", hilo_rdata); end
    rst = 1'b0; hiloren = 2'b00;
    $display("[TB] reset released");
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    bit          sgn;
    logic [63:0] exp;
    int          n;
    logic        fb;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      begin a = 32'hFFFF_FFFF; b = 32'd2; sgn = 1'b0; end
      else if (i == 1) begin a = 32'hFFFF_FFFD; b = 32'd7; sgn = 1'b1; end
      else begin a = rand_operand(); b = rand_operand(); sgn = 1'($urandom_range(0, 1)); end
      exp = model(1'b1, sgn, a, b);
      run_op(1'b1, sgn, a, b, n, fb);
      $display("[TB] mult sgn=%0d a=%h b=%h stall=%0d hi=%h lo=%h", sgn, a, b, n, hi, lo);
      tests_run++; if (n != 2) begin tests_failed++; $display("FAIL mult_stall: got %0d expected 2", n); end
      tests_run++; if (hi !== exp[63:32]) begin tests_failed++; $display("FAIL mult_hi: got %h expected %h", hi, exp[63:32]); end
      tests_run++; if (lo !== exp[31:0]) begin tests_failed++; $display("FAIL mult_lo: got %h expected %h", lo, exp[31:0]); end
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    bit          sgn;
    logic [63:0] exp;
    int          n;
    logic        fb;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      begin a = 32'hFFFF_FFF9; b = 32'd2; sgn = 1'b1; end
      else if (i == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sgn = 1'b1; end
      else if (i == 2) begin a = 32'd100; b = 32'd7; sgn = 1'b0; end
      else begin
        a = rand_operand(); b = rand_operand(); sgn = 1'($urandom_range(0, 1));
        if (b == 32'd0) b = 32'd3;
      end
      exp = model(1'b0, sgn, a, b);
      run_op(1'b0, sgn, a, b, n, fb);
      $display("[TB] div sgn=%0d a=%h b=%h stall=%0d hi=%h lo=%h", sgn, a, b, n, hi, lo);
      tests_run++; if (n != 33) begin tests_failed++; $display("FAIL div_stall: got %0d expected 33", n); end
      tests_run++; if (hi !== exp[63:32]) begin tests_failed++; $display("FAIL div_hi: got %h expected %h", hi, exp[63:32]); end
      tests_run++; if (lo !== exp[31:0]) begin tests_failed++; $display("FAIL div_lo: got %h expected %h", lo, exp[31:0]); end
    end
  endtask

  task automatic test_div0();
    int   n;
    logic fb;
    run_op(1'b0, 1'b0, 32'd100, 32'd0, n, fb);
    $display("[TB] divu 100/0 stall=%0d hi=%h lo=%h", n, hi, lo);
    tests_run++; if (n != DIV0_STALL) begin tests_failed++; $display("FAIL div0u_stall: got %0d expected %0d", n, DIV0_STALL); end
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div0u_lo: got %h expected ffffffff", lo); end
    tests_run++; if (hi !== 32'd100) begin tests_failed++; $display("FAIL div0u_hi: got %h expected 00000064", hi); end
    hiloren = 2'b01; #1;
    tests_run++; if (hilo_rdata !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mflo: got %h expected ffffffff", hilo_rdata); end
    hiloren = 2'b10; #1;
    tests_run++; if (hilo_rdata !== 32'd100) begin tests_failed++; $display("FAIL mfhi: got %h expected 00000064", hilo_rdata); end
    hiloren = 2'b00; #1;
    tests_run++; if (hilo_rdata !== 32'd0) begin tests_failed++; $display("FAIL rdata_idle: got %h expected 0", hilo_rdata); end
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd0, n, fb);
    $display("[TB] div -7/0 stall=%0d hi=%h lo=%h", n, hi, lo);
    tests_run++; if (n != DIV0_STALL) begin tests_failed++; $display("FAIL div0s_stall: got %0d expected %0d", n, DIV0_STALL); end
    tests_run++; if (lo !== 32'd1) begin tests_failed++; $display("FAIL div0s_lo: got %h expected 00000001", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFF9) begin tests_failed++; $display("FAIL div0s_hi: got %h expected fffffff9", hi); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    hilowen = 2'b11; src_a = 32'h1234_5678;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL mt_stall: got %b expected 0", stall); end
    @(negedge clk);
    hilowen = 2'b00;
    tests_run++; if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin tests_failed++; $display("FAIL mt_write: got hi=%h lo=%h expected 12345678", hi, lo); end
    // DIVU 100/7, flushed in the tenth DIV cycle
    start_valid = 1'b1; mult = 1'b0; div = 1'b1; mdsign = 1'b0; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_stall: got %b expected 0", stall); end
    @(negedge clk);
    flush = 1'b0; mult = 1'b1; div = 1'b0; src_a = 32'd3; src_b = 32'd5; #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_idle: busy got %b expected 0", busy); end
    tests_run++; if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin tests_failed++; $display("FAIL flush_hilo: got hi=%h lo=%h expected 12345678", hi, lo); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL reissue_stall: got %b expected 1", stall); end
    repeat (2) @(negedge clk);
    start_valid = 1'b0; mult = 1'b0;
    $display("[TB] flushed divu then multu 3*5 hi=%h lo=%h", hi, lo);
    tests_run++; if (lo !== 32'd15 || hi !== 32'd0) begin tests_failed++; $display("FAIL post_flush_mult: got hi=%h lo=%h expected 0/15", hi, lo); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL fin_busy: got %b expected 1", busy); end
  endtask

  // A flush on the MUL completion edge must drop the product and any MTLO.
  task automatic test_flush_mul();
    @(negedge clk);
    hilowen = 2'b11; src_a = 32'hCAFE_0001;
    @(negedge clk);
    hilowen = 2'b00;
    start_valid = 1'b1; mult = 1'b1; mdsign = 1'b0; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    @(negedge clk);
    flush = 1'b1; hilowen = 2'b01; src_a = 32'hDEAD_BEEF; #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_mul_stall: got %b expected 0", stall); end
    @(negedge clk);
    flush = 1'b0; hilowen = 2'b00; start_valid = 1'b0; mult = 1'b0; #1;
    $display("[TB] multu flushed on completion hi=%h lo=%h", hi, lo);
    tests_run++; if (hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL flush_mul_hilo: got hi=%h lo=%h expected cafe0001", hi, lo); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_mul_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    start_valid = 1'b1; div = 1'b1; mdsign = 1'b0; src_a = 32'($urandom); src_b = 32'd9;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_valid = 1'b0; div = 1'b0; #1;
    tests_run++; if (hi !== 32'd0 || lo !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h expected 0", hi, lo); end
    tests_run++; if (stall !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ctl: got stall=%b busy=%b expected 0/0", stall, busy); end
    hilowen = 2'b10; src_a = 32'hA5A5_A5A5; #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL mthi_stall: got %b expected 0", stall); end
    @(negedge clk);
    hilowen = 2'b00; hiloren = 2'b10; #1;
    $display("[TB] reset mid-div then mthi hi=%h rdata=%h", hi, hilo_rdata);
    tests_run++; if (hilo_rdata !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL mthi_read: got %h expected a5a5a5a5", hilo_rdata); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL mthi_lo: got %h expected 0", lo); end
    hiloren = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    bit          sgn, is_mult;
    logic [63:0] exp;
    int          n, exp_n;
    logic        fb;
    for (int i = 0; i < 12; i++) begin
      is_mult = 1'($urandom_range(0, 1));
      sgn     = 1'($urandom_range(0, 1));
      a = rand_operand();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : rand_operand();
      exp   = model(is_mult, sgn, a, b);
      exp_n = is_mult ? 2 : ((b == 32'd0) ? DIV0_STALL : 33);
      run_op(is_mult, sgn, a, b, n, fb);
      $display("[TB] b2b mult=%0d sgn=%0d a=%h b=%h stall=%0d hi=%h lo=%h", is_mult, sgn, a, b, n, hi, lo);
      tests_run++; if (n != exp_n) begin tests_failed++; $display("FAIL b2b_stall: got %0d expected %0d", n, exp_n); end
      tests_run++; if (fb !== 1'b1) begin tests_failed++; $display("FAIL b2b_fin_busy: got %b expected 1", fb); end
      hiloren = 2'b01; #1;
      tests_run++; if (hilo_rdata !== exp[31:0]) begin tests_failed++; $display("FAIL b2b_lo: got %h expected %h", hilo_rdata, exp[31:0]); end
      hiloren = 2'b10; #1;
      tests_run++; if (hilo_rdata !== exp[63:32]) begin tests_failed++; $display("FAIL b2b_hi: got %h expected %h", hilo_rdata, exp[63:32]); end
      hiloren = 2'b00;
    end
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; mult = 1'b0; div = 1'b0; mdsign = 1'b0;
    src_a = 32'd0; src_b = 32'd0; hilowen = 2'b00; hiloren = 2'b00; flush = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_flush();
    test_flush_mul();
    test_reset_mid_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer and owner of the HI/LO register pair for the EX stage.
- Accepts MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO controls from the decoder: mult, div, mdsign, hilowen, hiloren.
- Multiplies in a single registered step; divides with a 32-iteration restoring divider.
- Holds the pipeline with a stall output until HI/LO are updated, and aborts in-flight work on an exception/ERET flush.

Parameters:
- DIV_ITER, 32, number of divider iterations. Fixed at 32 for 32-bit operands; no other values are supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  EX instruction valid and (mult or div)
- mult  in  1  multiply request (from decoder)
- div  in  1  divide request (from decoder)
- mdsign  in  1  1: signed operation, 0: unsigned
- src_a  in  32  GPR[rs]; also MTHI/MTLO write data
- src_b  in  32  GPR[rt]
- hilowen  in  2  bit0 writes LO, bit1 writes HI (MTLO/MTHI only; start_valid=0 in that cycle)
- hiloren  in  2  2'b01 read LO, 2'b10 read HI
- flush  in  1  exception/ERET cancel
- stall  out  1  hold EX and earlier stages
- busy  out  1  state != IDLE
- hilo_rdata  out  32  selected HI/LO value, combinational from the registers; 0 when hiloren=0
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: state=IDLE, hi=lo=0, counter=0, stall=0, busy=0, and all operand/remainder/quotient registers cleared.
- States: IDLE, MUL, DIV, FIN.
- IDLE, start_valid=1 and flush=0 (accept):
  - Latch operands.
  - If mdsign=1, latch |src_a|, |src_b| plus the two sign bits; otherwise latch raw values.
  - Next state MUL if mult=1 (mult has priority if both are set), else DIV with counter=0.
- MUL:
  - One cycle; 64-bit product computed from the latched operands.
  - Signed product is negated if the signs differ.
  - On the edge: hi=product[63:32], lo=product[31:0], go to FIN.
- DIV, one restoring step per cycle:
  - Shift {rem,quo} left by 1.
  - If the shifted rem >= divisor: subtract and set quotient bit to 1.
  - counter increments each cycle.
  - After DIV_ITER steps, on the edge: lo=quotient, hi=remainder, go to FIN.
  - Signed fixup: quotient negated if the signs differ; remainder takes the dividend's sign.
- FIN: stall=0; start_valid is ignored so the held instruction is not re-accepted; next state IDLE.
- stall = (IDLE and start_valid and !flush) or state==MUL or state==DIV.
- Stall cycles: multiply 2 (accept + MUL); divide 33 (accept + 32).
- Divide by zero, unsigned: quotient=32'hFFFFFFFF, remainder=dividend.
- Divide by zero, signed: the same values, then the sign fixup is applied. This is the natural restoring result; no special case exists without the optional feature.
- MTHI/MTLO: in IDLE or FIN with flush=0, write src_a into the selected register(s) on the edge, with no stall. If MUL/DIV also writes HI/LO on the same edge, the MUL/DIV result wins.
- MFHI/MFLO: hilo_rdata shows the register value as of the current cycle; an op completing on this edge is visible from the next cycle (FIN onward).
- flush=1 in any state:
  - Next state IDLE; hi/lo not written; hilowen and start_valid ignored; stall=0 that cycle.
  - A flush on the completion edge (MUL, or the last DIV cycle) suppresses the HI/LO write.
- busy is high in MUL, DIV and FIN.

Optional Feature:
- MDU_DIV0_EARLY_EN, when defined:
  - DIV checks the latched divisor in its first cycle. If it is zero, DIV writes the unsigned divide-by-zero values above (with sign fixup) and moves to FIN after that single cycle, so the stall is 2 cycles.
  - HI/LO values are identical to those of the undefined build; only latency differs.
- When undefined: no check; divide by zero takes the full 33 stall cycles.

Test Plan:
- MULTU src_a=32'hFFFFFFFF, src_b=32'h2 -> stall high 2 cycles; then hi=32'h00000001, lo=32'hFFFFFFFE.
- MULT src_a=-3 (32'hFFFFFFFD), src_b=7 -> stall high 2 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB (-21).
- DIV src_a=-7, src_b=2 -> stall high exactly 33 cycles; then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU src_a=100, src_b=0:
  - macro undefined -> 33 stall cycles.
  - macro defined -> 2 stall cycles.
  - both -> lo=32'hFFFFFFFF, hi=100.
- DIVU 100/7 with flush pulsed in DIV cycle 10 -> stall drops that cycle, state IDLE, hi/lo keep prior values. A new MULTU 3*5 next cycle -> lo=15, hi=0.
- Reset mid-DIV -> hi=lo=0, stall=0, busy=0 next cycle. Then MTHI src_a=32'hA5A5A5A5 -> hi updated next cycle with no stall; hiloren=2'b10 -> hilo_rdata=32'hA5A5A5A5.
